// File: rtl/cache_fsm.sv
// rtl/cache_fsm.sv - 4-way set-associative write-back/write-allocate L1 data cache controller and storage
//
// Holds valid/dirty/replacement state plus tag and data arrays. Each request
// goes through lookup and, on a miss, an optional dirty-victim write-back and
// a block refill.
//
// Build option: CACHE_LRU_EN selects true-LRU replacement. Without it, each
// set uses a round-robin pointer.
//
// Ports:
//   clk        : clock; all state changes on the rising edge
//   rst_n      : asynchronous reset, ACTIVE-HIGH despite the name
//   rd_en      : load request, sampled while ready=1
//   wr_en      : store request, sampled while ready=1 (rd_en wins if both set)
//   addr       : byte address {tag, index, word, byte}
//   data_wr    : store data
//   ready      : controller idle, a new request may be accepted
//   done       : one-cycle completion pulse
//   hit        : with done, 1 when the first lookup hit
//   word_out   : load result, held until the next load completes
//   byte_out   : little-endian byte of word_out selected by addr[1:0]
//   mem_addr   : block-aligned memory address
//   mem_rd_en  : block refill request (level)
//   mem_wr_en  : block write-back request (level)
//   mem_wr_blk : victim block being written back
//   mem_rd_blk : refill block, sampled on the edge where mem_ack=1
//   mem_ack    : memory completion of the current request
module cache_fsm #(
  parameter int BYTE      = 8,
  parameter int NWAYS     = 4,
  parameter int NSETS     = 128,
  parameter int BLK_WIDTH = 512,
  parameter int MEM_WIDTH = 512,
  parameter int PA_WIDTH  = 32,
  parameter int WRD_WIDTH = 32,
  parameter int BO_WIDTH  = 6,
  parameter int WO_WIDTH  = 4,
  parameter int IDX_WIDTH = 7,
  parameter int TAG_WIDTH = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [PA_WIDTH-1:0]  addr,
  input  logic [WRD_WIDTH-1:0] data_wr,
  output logic                 ready,
  output logic                 done,
  output logic                 hit,
  output logic [WRD_WIDTH-1:0] word_out,
  output logic [BYTE-1:0]      byte_out,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [MEM_WIDTH-1:0] mem_wr_blk,
  input  logic [MEM_WIDTH-1:0] mem_rd_blk,
  input  logic                 mem_ack
);

  localparam int WAY_W = $clog2(NWAYS);
  localparam int BS_W  = BO_WIDTH - WO_WIDTH;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state_q, state_d;

  logic [PA_WIDTH-1:0]  req_addr;
  logic [WRD_WIDTH-1:0] req_data;
  logic                 req_wr;
  logic                 first_hit_q;
  logic [WAY_W-1:0]     victim_q;

  logic [NWAYS-1:0]     valid_q [NSETS];
  logic [NWAYS-1:0]     dirty_q [NSETS];
  logic [TAG_WIDTH-1:0] tag_q   [NSETS][NWAYS];
  logic [BLK_WIDTH-1:0] data_q  [NSETS][NWAYS];
`ifdef CACHE_LRU_EN
  logic [WAY_W-1:0]     lru_q   [NSETS][NWAYS];
  logic [WAY_W-1:0]     lru_way;
`else
  logic [WAY_W-1:0]     rr_q    [NSETS];
`endif

  logic [TAG_WIDTH-1:0] req_tag;
  logic [IDX_WIDTH-1:0] req_idx;
  logic [WO_WIDTH-1:0]  req_wo;
  logic [BS_W-1:0]      req_bs;
  logic                 hit_any;
  logic [WAY_W-1:0]     hit_way;
  logic                 found_inv;
  logic [WAY_W-1:0]     inv_way;
  logic [WAY_W-1:0]     victim_sel;
  logic [WRD_WIDTH-1:0] hit_word;

  assign req_tag  = req_addr[PA_WIDTH-1 -: TAG_WIDTH];
  assign req_idx  = req_addr[BO_WIDTH +: IDX_WIDTH];
  assign req_wo   = req_addr[BS_W +: WO_WIDTH];
  assign req_bs   = req_addr[BS_W-1:0];
  assign hit_word = data_q[req_idx][hit_way][int'(req_wo)*WRD_WIDTH +: WRD_WIDTH];
  assign ready    = (state_q == IDLE);

  // Tag match and lowest-indexed invalid way in the addressed set
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    found_inv = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (!hit_any && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found_inv && !valid_q[req_idx][w]) begin
        found_inv = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

`ifdef CACHE_LRU_EN
  // Oldest way carries age NWAYS-1; ages form a permutation so exactly one matches
  always_comb begin
    lru_way = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (lru_q[req_idx][w] == WAY_W'(NWAYS - 1)) lru_way = WAY_W'(w);
    end
  end
  assign victim_sel = found_inv ? inv_way : lru_way;
`else
  assign victim_sel = found_inv ? inv_way : rr_q[req_idx];
`endif

  // Next state and memory-port outputs (purely state-decoded so an async
  // reset drops the memory requests immediately)
  always_comb begin
    state_d    = state_q;
    mem_addr   = '0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_wr_blk = '0;
    case (state_q)
      IDLE: begin
        if (rd_en || wr_en) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit_any) state_d = IDLE;
        else if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel]) state_d = WRITEBACK;
        else state_d = ALLOCATE;
      end
      WRITEBACK: begin
        mem_wr_en  = 1'b1;
        mem_addr   = {tag_q[req_idx][victim_q], req_idx, BO_WIDTH'(0)};
        mem_wr_blk = data_q[req_idx][victim_q];
        if (mem_ack) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_rd_en = 1'b1;
        mem_addr  = {req_tag, req_idx, BO_WIDTH'(0)};
        if (mem_ack) state_d = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= IDLE;
      req_addr    <= '0;
      req_data    <= '0;
      req_wr      <= 1'b0;
      first_hit_q <= 1'b0;
      victim_q    <= '0;
      done        <= 1'b0;
      hit         <= 1'b0;
      word_out    <= '0;
      byte_out    <= '0;
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
`ifdef CACHE_LRU_EN
        for (int w = 0; w < NWAYS; w++) lru_q[s][w] <= WAY_W'(w);
`else
        rr_q[s] <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_en || wr_en) begin
            req_addr    <= addr;
            req_data    <= data_wr;
            req_wr      <= !rd_en;
            first_hit_q <= 1'b1;
          end
        end
        COMPARE: begin
          if (hit_any) begin
            done <= 1'b1;
            hit  <= first_hit_q;
            if (req_wr) begin
              dirty_q[req_idx][hit_way] <= 1'b1;
            end else begin
              word_out <= hit_word;
              byte_out <= hit_word[int'(req_bs)*BYTE +: BYTE];
            end
`ifdef CACHE_LRU_EN
            // Ways younger than the hit way age by one; the hit way becomes 0
            for (int w = 0; w < NWAYS; w++) begin
              if (WAY_W'(w) == hit_way) lru_q[req_idx][w] <= '0;
              else if (lru_q[req_idx][w] < lru_q[req_idx][hit_way])
                lru_q[req_idx][w] <= lru_q[req_idx][w] + 1'b1;
            end
`endif
          end else begin
            first_hit_q <= 1'b0;
            victim_q    <= victim_sel;
`ifndef CACHE_LRU_EN
            // Pointer only advances when a full set has to give up a line
            if (!found_inv) rr_q[req_idx] <= rr_q[req_idx] + 1'b1;
`endif
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; writes are gated by state, which is
  // forced to IDLE while reset is held
  always_ff @(posedge clk) begin
    if (state_q == COMPARE && hit_any && req_wr)
      data_q[req_idx][hit_way][int'(req_wo)*WRD_WIDTH +: WRD_WIDTH] <= req_data;
    if (state_q == ALLOCATE && mem_ack) begin
      data_q[req_idx][victim_q] <= mem_rd_blk;
      tag_q[req_idx][victim_q]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_cache_fsm.sv
// tb/tb_cache_fsm.sv - self-checking bench for cache_fsm
module tb_cache_fsm;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         rd_en = 1'b0;
  logic         wr_en = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  data_wr = '0;
  logic         ready, done, hit;
  logic [31:0]  word_out;
  logic [7:0]   byte_out;
  logic [31:0]  mem_addr;
  logic         mem_rd_en, mem_wr_en;
  logic [511:0] mem_wr_blk;
  logic [511:0] mem_rd_blk = '0;
  logic         mem_ack = 1'b0;

  always #5 clk = ~clk;

  cache_fsm dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .data_wr(data_wr), .ready(ready), .done(done), .hit(hit),
    .word_out(word_out), .byte_out(byte_out), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_wr_blk(mem_wr_blk),
    .mem_rd_blk(mem_rd_blk), .mem_ack(mem_ack)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: main memory plus a per-set list of lines
  logic [511:0] mem_m [int unsigned];
  bit           m_valid [128][4];
  bit           m_dirty [128][4];
  logic [18:0]  m_tag   [128][4];
  logic [511:0] m_data  [128][4];
  longint       m_stamp [128][4];
  int           m_ptr   [128];
  longint       now;
  logic [31:0]  last_word;
  logic [7:0]   last_byte;

  // What the responder saw during the most recent access
  int           obs_nwb, obs_nrd;
  logic [31:0]  obs_wba, obs_rda;
  logic [511:0] obs_wbb;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mem_get(input logic [31:0] ba);
    logic [511:0] b;
    if (mem_m.exists(ba >> 6)) return mem_m[ba >> 6];
    for (int w = 0; w < 16; w++) b[32*w +: 32] = ba ^ (32'h9E3779B9 * (w + 1));
    return b;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 128; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_stamp[s][w] = 0;
      end
    end
    now = 0;
    last_word = '0;
    last_byte = '0;
  endtask

  task automatic mdl(input logic [31:0] a, input bit wr, input logic [31:0] d,
                     output bit e_hit, output bit e_wb, output logic [31:0] e_wba,
                     output logic [511:0] e_wbb, output bit e_rd,
                     output logic [31:0] e_rda, output logic [511:0] e_rdb);
    int s, w, wo;
    logic [18:0] t;
    s = int'(a[12:6]);
    t = a[31:13];
    wo = int'(a[5:2]);
    w = -1;
    e_wb = 0; e_rd = 0; e_wba = '0; e_wbb = '0; e_rda = '0; e_rdb = '0;
    for (int i = 0; i < 4; i++) if (w < 0 && m_valid[s][i] && m_tag[s][i] == t) w = i;
    e_hit = (w >= 0);
    if (w < 0) begin
      for (int i = 0; i < 4; i++) if (w < 0 && !m_valid[s][i]) w = i;
      if (w < 0) begin
`ifdef CACHE_LRU_EN
        w = 0;
        for (int i = 1; i < 4; i++) if (m_stamp[s][i] < m_stamp[s][w]) w = i;
`else
        w = m_ptr[s];
        m_ptr[s] = (m_ptr[s] + 1) % 4;
`endif
        if (m_dirty[s][w]) begin
          e_wb  = 1;
          e_wba = {m_tag[s][w], a[12:6], 6'b0};
          e_wbb = m_data[s][w];
          mem_m[e_wba >> 6] = e_wbb;
        end
      end
      e_rd  = 1;
      e_rda = {a[31:6], 6'b0};
      e_rdb = mem_get(e_rda);
      m_valid[s][w] = 1;
      m_dirty[s][w] = 0;
      m_tag[s][w]   = t;
      m_data[s][w]  = e_rdb;
    end
    now++;
    m_stamp[s][w] = now;
    if (wr) begin
      m_data[s][w][32*wo +: 32] = d;
      m_dirty[s][w] = 1;
    end else begin
      last_word = m_data[s][w][32*wo +: 32];
      last_byte = 8'(last_word >> (8 * int'(a[1:0])));
    end
  endtask

  // One request: predict with the model, drive the DUT, act as memory, check
  task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] d, input string tag);
    bit e_hit, e_wb, e_rd, in_req, got_done;
    logic [31:0] e_wba, e_rda;
    logic [511:0] e_wbb, e_rdb;
    int mem_cyc, waitc, iter, excl;
    mdl(a, wr && !rd, d, e_hit, e_wb, e_wba, e_wbb, e_rd, e_rda, e_rdb);
    obs_nwb = 0; obs_nrd = 0; obs_wba = '0; obs_rda = '0; obs_wbb = '0;
    in_req = 0; got_done = 0; mem_cyc = 0; waitc = 0; iter = 0; excl = 0;
    chk({tag, "/ready"}, ready, 1'b1);
    rd_en = rd; wr_en = wr; addr = a; data_wr = d;
    @(negedge clk);
    rd_en = 0; wr_en = 0;
    while (iter < 200) begin
      mem_ack = 0;
      if (done) begin
        got_done = 1;
        break;
      end
      if (mem_rd_en || mem_wr_en) begin
        mem_cyc++;
        if (mem_rd_en && mem_wr_en) excl++;
        if (!in_req) begin
          in_req = 1;
          waitc = $urandom_range(0, 3);
          if (mem_wr_en) begin obs_nwb++; obs_wba = mem_addr; obs_wbb = mem_wr_blk; end
          if (mem_rd_en) begin obs_nrd++; obs_rda = mem_addr; end
        end
        if (waitc == 0) begin
          mem_ack = 1;
          mem_rd_blk = e_rdb;
          in_req = 0;
        end else begin
          waitc--;
        end
      end
      @(negedge clk);
      iter++;
    end
    mem_ack = 0;
    chk({tag, "/done"}, got_done, 1'b1);
    chk({tag, "/latency"}, iter, 1 + mem_cyc + (e_hit ? 0 : 1));
    chk({tag, "/hit"}, hit, e_hit);
    chk({tag, "/excl"}, excl, 0);
    chk({tag, "/n_wb"}, obs_nwb, e_wb);
    chk({tag, "/n_rd"}, obs_nrd, e_rd);
    if (e_wb) begin
      chk({tag, "/wb_addr"}, obs_wba, e_wba);
      chk({tag, "/wb_blk"}, obs_wbb, e_wbb);
    end
    if (e_rd) chk({tag, "/rd_addr"}, obs_rda, e_rda);
    chk({tag, "/word"}, word_out, last_word);
    chk({tag, "/byte"}, byte_out, last_byte);
    @(negedge clk);
    chk({tag, "/done_pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [511:0] b;
    int sets [4] = '{0, 1, 65, 127};
    int k;
    logic [31:0] ra;
    bit rr, rw;

    model_reset();
    b = mem_get(32'h0000_1040);
    b[63:32] = 32'hDEADBEEF;
    mem_m[32'h0000_1040 >> 6] = b;

    repeat (2) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rst/ready", ready, 1'b1);
    chk("rst/done", done, 1'b0);
    chk("rst/hit", hit, 1'b0);
    chk("rst/word", word_out, 32'h0);
    chk("rst/byte", byte_out, 8'h0);
    chk("rst/mem_rd_en", mem_rd_en, 1'b0);
    chk("rst/mem_wr_en", mem_wr_en, 1'b0);
    chk("rst/mem_addr", mem_addr, 32'h0);
    chk("rst/mem_wr_blk", mem_wr_blk, 512'h0);

    access(32'h0000_1044, 1, 0, 0, "cold");
    chk("cold/rd_addr_c", obs_rda, 32'h0000_1040);
    chk("cold/word_c", word_out, 32'hDEADBEEF);
    chk("cold/byte_c", byte_out, 8'hEF);
    access(32'h0000_1047, 1, 0, 0, "rehit");
    chk("rehit/byte_c", byte_out, 8'hDE);
    chk("rehit/nomem", obs_nrd + obs_nwb, 0);

    access(32'h0000_1044, 0, 1, 32'h12345678, "wrhit");
    chk("wrhit/hit_c", hit, 1'b1);
    access(32'h0000_1044, 1, 0, 0, "rdback");
    chk("rdback/word_c", word_out, 32'h12345678);

    access(32'h0000_3044, 1, 0, 0, "fill3");
    access(32'h0000_5044, 1, 0, 0, "fill5");
    access(32'h0000_7044, 1, 0, 0, "fill7");
    access(32'h0000_9044, 1, 0, 0, "dirty_ev");
    chk("dirty_ev/wb_addr_c", obs_wba, 32'h0000_1040);
    chk("dirty_ev/wb_word1_c", obs_wbb[63:32], 32'h12345678);
    chk("dirty_ev/rd_addr_c", obs_rda, 32'h0000_9040);
    access(32'h0000_B044, 1, 0, 0, "clean_ev");
    chk("clean_ev/n_wb_c", obs_nwb, 0);
    chk("clean_ev/rd_addr_c", obs_rda, 32'h0000_B040);

    access(32'h0000_9044, 1, 1, 32'hCAFEF00D, "rdwr");
    chk("rdwr/hit_c", hit, 1'b1);
    access(32'h0000_9044, 1, 0, 0, "rdwr_chk");

    // Abort a refill with reset; set 2 is empty so no write-back precedes it
    rd_en = 1; addr = 32'h0000_2084;
    @(negedge clk);
    rd_en = 0;
    k = 0;
    while (!mem_rd_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("abort/mem_rd_en_before", mem_rd_en, 1'b1);
    #2 rst_n = 1;
    #1;
    chk("abort/mem_rd_en_after", mem_rd_en, 1'b0);
    chk("abort/mem_wr_en_after", mem_wr_en, 1'b0);
    chk("abort/ready_after", ready, 1'b1);
    model_reset();
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    access(32'h0000_1044, 1, 0, 0, "post_rst");
    chk("post_rst/hit_c", hit, 1'b0);

    for (int i = 0; i < 400; i++) begin
      ra = {19'($urandom_range(0, 5) + 19'h40), 7'(sets[$urandom_range(0, 3)]),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      rr = ($urandom_range(0, 2) != 0);
      rw = !rr || ($urandom_range(0, 9) == 0);
      access(ra, rr, rw, $urandom, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
